// File: rtl/itcm_arbiter_pkg.sv
// Shared ITCM arbiter constants: port indices, address width,
// and the default IFU starvation threshold.
package itcm_arbiter_pkg;
  localparam int ITCM_ADDR_WIDTH  = 16;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int NPORTS           = 3;
  localparam int PORT_IFU         = 0;
  localparam int PORT_LSU         = 1;
  localparam int PORT_DBG         = 2;
endpackage

// File: rtl/itcm_rsp_buf.sv
// One-entry ITCM response buffer: passes the RAM word through in the
// cycle after a grant and parks it here if the consumer stalls.
module itcm_rsp_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata
);

  logic        buf_v_q, buf_v_d;
  logic [31:0] buf_d_q, buf_d_d;

  always_comb begin
    buf_v_d   = buf_v_q;
    buf_d_d   = buf_d_q;
    rsp_valid = buf_v_q | in_valid;
    rsp_rdata = '0;
    if (buf_v_q) begin
      rsp_rdata = buf_d_q;
      buf_v_d   = ~rsp_ready;
    end else if (in_valid) begin
      rsp_rdata = in_data;
      if (!rsp_ready) begin
        buf_v_d = 1'b1;
        buf_d_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v_q <= 1'b0;
      buf_d_q <= '0;
    end else begin
      buf_v_q <= buf_v_d;
      buf_d_q <= buf_d_d;
    end
  end

endmodule

// File: rtl/itcm_arbiter.sv
// Three-port (ifu/lsu/dbg) ITCM arbiter with fixed priority, per-port
// response buffering and an IFU anti-starvation boost.
module itcm_arbiter
  import itcm_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = ITCM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_req_we,
  input  logic [3:0]            ifu_req_be,
  input  logic [31:0]           ifu_req_wdata,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [31:0]           ifu_rsp_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic                  lsu_req_we,
  input  logic [3:0]            lsu_req_be,
  input  logic [31:0]           lsu_req_wdata,
  output logic                  lsu_rsp_valid,
  input  logic                  lsu_rsp_ready,
  output logic [31:0]           lsu_rsp_rdata,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  input  logic                  dbg_req_we,
  input  logic [3:0]            dbg_req_be,
  input  logic [31:0]           dbg_req_wdata,
  output logic                  dbg_rsp_valid,
  input  logic                  dbg_rsp_ready,
  output logic [31:0]           dbg_rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [NPORTS-1:0] req_v, rsp_r, rsp_v;
  logic [NPORTS-1:0] elig, cand, gnt;
  logic [NPORTS-1:0] infl_q, infl_d;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              boost;
  logic [31:0]       rsp_rd [NPORTS];
  logic [31:0]       in_data;
  logic              unused_addr_lo;

  assign req_v = {dbg_req_valid, lsu_req_valid, ifu_req_valid};
  assign rsp_r = {dbg_rsp_ready, lsu_rsp_ready, ifu_rsp_ready};

  // A port may issue again only once its previous response leaves.
  assign elig  = ~rsp_v | rsp_r;
  assign cand  = req_v & elig & {NPORTS{rst_n}};
  assign boost = (cnt_q == CW'(STARVE_LIMIT));

  always_comb begin
    gnt = '0;
    priority case (1'b1)
      boost && cand[PORT_IFU]: gnt[PORT_IFU] = 1'b1;
      cand[PORT_DBG]:          gnt[PORT_DBG] = 1'b1;
      cand[PORT_LSU]:          gnt[PORT_LSU] = 1'b1;
      cand[PORT_IFU]:          gnt[PORT_IFU] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      gnt[PORT_DBG]: begin
        ram_cs    = 1'b1;
        ram_we    = dbg_req_we;
        ram_be    = dbg_req_be;
        ram_addr  = dbg_req_addr[ADDR_WIDTH-1:2];
        ram_wdata = dbg_req_wdata;
      end
      gnt[PORT_LSU]: begin
        ram_cs    = 1'b1;
        ram_we    = lsu_req_we;
        ram_be    = lsu_req_be;
        ram_addr  = lsu_req_addr[ADDR_WIDTH-1:2];
        ram_wdata = lsu_req_wdata;
      end
      gnt[PORT_IFU]: begin
        ram_cs    = 1'b1;
        ram_we    = ifu_req_we;
        ram_be    = ifu_req_be;
        ram_addr  = ifu_req_addr[ADDR_WIDTH-1:2];
        ram_wdata = ifu_req_wdata;
      end
      default: ;
    endcase
  end

  assign unused_addr_lo = ^{ifu_req_addr[1:0], lsu_req_addr[1:0],
                            dbg_req_addr[1:0]};

  assign ifu_req_ready = gnt[PORT_IFU];
  assign lsu_req_ready = gnt[PORT_LSU];
  assign dbg_req_ready = gnt[PORT_DBG];

  always_comb begin
    infl_d = gnt;
    we_d   = ram_we;
    cnt_d  = cnt_q;
    if (!ifu_req_valid || gnt[PORT_IFU]) begin
      cnt_d = '0;
    end else if (!boost) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      infl_q <= infl_d;
      we_q   <= we_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_data = we_q ? 32'h0 : ram_rdata;

  for (genvar p = 0; p < NPORTS; p++) begin : g_buf
    itcm_rsp_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (infl_q[p]),
      .in_data   (in_data),
      .rsp_valid (rsp_v[p]),
      .rsp_ready (rsp_r[p]),
      .rsp_rdata (rsp_rd[p])
    );
  end

  assign ifu_rsp_valid = rsp_v[PORT_IFU];
  assign lsu_rsp_valid = rsp_v[PORT_LSU];
  assign dbg_rsp_valid = rsp_v[PORT_DBG];
  assign ifu_rsp_rdata = rsp_rd[PORT_IFU];
  assign lsu_rsp_rdata = rsp_rd[PORT_LSU];
  assign dbg_rsp_rdata = rsp_rd[PORT_DBG];

endmodule

// File: tb/tb_itcm_arbiter.sv
// Directed bench for itcm_arbiter with a behavioural one-cycle SRAM.
module tb_itcm_arbiter;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_req_valid, ifu_req_ready, ifu_req_we;
  logic [AW-1:0] ifu_req_addr;
  logic [3:0]    ifu_req_be;
  logic [31:0]   ifu_req_wdata, ifu_rsp_rdata;
  logic          ifu_rsp_valid, ifu_rsp_ready;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_we;
  logic [AW-1:0] lsu_req_addr;
  logic [3:0]    lsu_req_be;
  logic [31:0]   lsu_req_wdata, lsu_rsp_rdata;
  logic          lsu_rsp_valid, lsu_rsp_ready;
  logic          dbg_req_valid, dbg_req_ready, dbg_req_we;
  logic [AW-1:0] dbg_req_addr;
  logic [3:0]    dbg_req_be;
  logic [31:0]   dbg_req_wdata, dbg_rsp_rdata;
  logic          dbg_rsp_valid, dbg_rsp_ready;
  logic          ram_cs, ram_we;
  logic [3:0]    ram_be;
  logic [AW-3:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  itcm_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_req_we(ifu_req_we),
    .ifu_req_be(ifu_req_be), .ifu_req_wdata(ifu_req_wdata),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_we(lsu_req_we),
    .lsu_req_be(lsu_req_be), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_addr(dbg_req_addr), .dbg_req_we(dbg_req_we),
    .dbg_req_be(dbg_req_be), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // SRAM: untouched words read as A000_00ww, word 4 preset to DEADBEEF
  bit [31:0] mem     [256];
  bit        mem_vld [256];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'd4) ? 32'hDEAD_BEEF : {24'hA0_0000, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        mem[ram_addr[7:0]] <= merge(mem_vld[ram_addr[7:0]] ?
          mem[ram_addr[7:0]] : init_word(ram_addr[7:0]), ram_wdata, ram_be);
        mem_vld[ram_addr[7:0]] <= 1'b1;
      end else begin
        ram_rdata <= mem_vld[ram_addr[7:0]] ?
          mem[ram_addr[7:0]] : init_word(ram_addr[7:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // index order in the packed fields: [2]=dbg [1]=lsu [0]=ifu
  typedef struct {
    logic [2:0]        req_v;
    logic [2:0]        rsp_r;
    logic [2:0][15:0]  addr;
    logic [2:0]        e_rdy;
    logic              e_cs;
    logic [13:0]       e_ra;
    logic [2:0]        e_rv;
    logic [2:0][31:0]  e_rd;
  } vec_t;

  vec_t vecs [15];

  task automatic apply(input vec_t v);
    ifu_req_valid = v.req_v[0];
    lsu_req_valid = v.req_v[1];
    dbg_req_valid = v.req_v[2];
    ifu_rsp_ready = v.rsp_r[0];
    lsu_rsp_ready = v.rsp_r[1];
    dbg_rsp_ready = v.rsp_r[2];
    ifu_req_addr  = v.addr[0];
    lsu_req_addr  = v.addr[1];
    dbg_req_addr  = v.addr[2];
  endtask

  task automatic idle();
    ifu_req_valid = 0; lsu_req_valid = 0; dbg_req_valid = 0;
    ifu_req_we = 0; lsu_req_we = 0; dbg_req_we = 0;
    ifu_req_be = 4'hF; lsu_req_be = 4'hF; dbg_req_be = 4'hF;
    ifu_req_wdata = 0; lsu_req_wdata = 0; dbg_req_wdata = 0;
    ifu_req_addr = 0; lsu_req_addr = 0; dbg_req_addr = 0;
    ifu_rsp_ready = 1; lsu_rsp_ready = 1; dbg_rsp_ready = 1;
  endtask

  logic [2:0]  rdy, rv;
  logic [31:0] rd [3];
  assign rdy = {dbg_req_ready, lsu_req_ready, ifu_req_ready};
  assign rv  = {dbg_rsp_valid, lsu_rsp_valid, ifu_rsp_valid};
  assign rd[0] = ifu_rsp_rdata;
  assign rd[1] = lsu_rsp_rdata;
  assign rd[2] = dbg_rsp_rdata;

  initial begin
    vecs[0]  = '{3'b001, 3'b111, {16'h0, 16'h0, 16'h10},
                 3'b001, 1'b1, 14'd4, 3'b000, {32'h0, 32'h0, 32'h0}};
    vecs[1]  = '{3'b000, 3'b111, {16'h0, 16'h0, 16'h0},
                 3'b000, 1'b0, 14'd0, 3'b001, {32'h0, 32'h0, 32'hDEADBEEF}};
    vecs[2]  = '{3'b111, 3'b111, {16'h8, 16'h4, 16'h0},
                 3'b100, 1'b1, 14'd2, 3'b000, {32'h0, 32'h0, 32'h0}};
    vecs[3]  = '{3'b011, 3'b111, {16'h8, 16'h4, 16'h0},
                 3'b010, 1'b1, 14'd1, 3'b100, {32'hA0000002, 32'h0, 32'h0}};
    vecs[4]  = '{3'b001, 3'b111, {16'h8, 16'h4, 16'h0},
                 3'b001, 1'b1, 14'd0, 3'b010, {32'h0, 32'hA0000001, 32'h0}};
    vecs[5]  = '{3'b000, 3'b111, {16'h0, 16'h0, 16'h0},
                 3'b000, 1'b0, 14'd0, 3'b001, {32'h0, 32'h0, 32'hA0000000}};
    vecs[6]  = '{3'b010, 3'b111, {16'h0, 16'h4, 16'h0},
                 3'b010, 1'b1, 14'd1, 3'b000, {32'h0, 32'h0, 32'h0}};
    vecs[7]  = '{3'b011, 3'b101, {16'h0, 16'hC, 16'h0},
                 3'b001, 1'b1, 14'd0, 3'b010, {32'h0, 32'hA0000001, 32'h0}};
    vecs[8]  = '{3'b010, 3'b101, {16'h0, 16'hC, 16'h0},
                 3'b000, 1'b0, 14'd0, 3'b011,
                 {32'h0, 32'hA0000001, 32'hA0000000}};
    vecs[9]  = '{3'b010, 3'b101, {16'h0, 16'hC, 16'h0},
                 3'b000, 1'b0, 14'd0, 3'b010, {32'h0, 32'hA0000001, 32'h0}};
    vecs[10] = '{3'b010, 3'b111, {16'h0, 16'hC, 16'h0},
                 3'b010, 1'b1, 14'd3, 3'b010, {32'h0, 32'hA0000001, 32'h0}};
    vecs[11] = '{3'b000, 3'b111, {16'h0, 16'h0, 16'h0},
                 3'b000, 1'b0, 14'd0, 3'b010, {32'h0, 32'hA0000003, 32'h0}};
    vecs[12] = '{3'b010, 3'b111, {16'h0, 16'h14, 16'h0},
                 3'b010, 1'b1, 14'd5, 3'b000, {32'h0, 32'h0, 32'h0}};
    vecs[13] = '{3'b010, 3'b111, {16'h0, 16'h1B, 16'h0},
                 3'b010, 1'b1, 14'd6, 3'b010, {32'h0, 32'hA0000005, 32'h0}};
    vecs[14] = '{3'b000, 3'b111, {16'h0, 16'h0, 16'h0},
                 3'b000, 1'b0, 14'd0, 3'b010, {32'h0, 32'hA0000006, 32'h0}};

    idle();
    rst_n = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rdy", {29'd0, rdy}, 0);
    chk("reset ram_cs", {31'd0, ram_cs}, 0);
    chk("reset rsp_valid", {29'd0, rv}, 0);
    chk("reset lsu rdata", lsu_rsp_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d req_ready", i), {29'd0, rdy}, {29'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d ram_cs", i), {31'd0, ram_cs}, {31'd0, vecs[i].e_cs});
      if (vecs[i].e_cs)
        chk($sformatf("v%0d ram_addr", i), {18'd0, ram_addr}, {18'd0, vecs[i].e_ra});
      chk($sformatf("v%0d rsp_valid", i), {29'd0, rv}, {29'd0, vecs[i].e_rv});
      for (int p = 0; p < 3; p++)
        if (vecs[i].e_rv[p])
          chk($sformatf("v%0d p%0d rdata", i, p), rd[p], vecs[i].e_rd[p]);
      next_cyc();
    end

    // dbg partial write then ifu read-back of merged word
    idle();
    dbg_req_valid = 1; dbg_req_we = 1; dbg_req_be = 4'b0011;
    dbg_req_addr = 16'h20; dbg_req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr dbg_ready", {31'd0, dbg_req_ready}, 1);
    chk("wr ram_we", {31'd0, ram_we}, 1);
    chk("wr ram_be", {28'd0, ram_be}, 32'h3);
    chk("wr ram_wdata", ram_wdata, 32'h1234_5678);
    chk("wr ram_addr", {18'd0, ram_addr}, 8);
    next_cyc();
    idle();
    ifu_req_valid = 1; ifu_req_addr = 16'h20;
    @(negedge clk);
    chk("wr dbg_rsp_valid", {31'd0, dbg_rsp_valid}, 1);
    chk("wr dbg_rdata", dbg_rsp_rdata, 0);
    chk("rd ifu_ready", {31'd0, ifu_req_ready}, 1);
    next_cyc();
    idle();
    @(negedge clk);
    chk("rd ifu_rsp_valid", {31'd0, ifu_rsp_valid}, 1);
    chk("rd ifu merged", ifu_rsp_rdata, 32'hA000_5678);
    next_cyc();

    // starvation: lsu streams, ifu waits 8 cycles then wins once
    idle();
    lsu_req_valid = 1; lsu_req_addr = 16'h4;
    ifu_req_valid = 1; ifu_req_addr = 16'h0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("starve c%0d ifu_ready", c), {31'd0, ifu_req_ready},
          (c == 9) ? 1 : 0);
      chk($sformatf("starve c%0d lsu_ready", c), {31'd0, lsu_req_ready},
          (c == 9) ? 0 : 1);
      next_cyc();
    end
    idle();
    next_cyc();

    // reset while an lsu access is in flight
    lsu_req_valid = 1; lsu_req_addr = 16'h8;
    @(negedge clk);
    chk("rst lsu granted", {31'd0, lsu_req_ready}, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst in-flight rsp_valid", {29'd0, rv}, 0);
    chk("rst in-flight rdata", lsu_rsp_rdata, 0);
    chk("rst in-flight ram_cs", {31'd0, ram_cs}, 0);
    chk("rst in-flight rdy", {29'd0, rdy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst c%0d rsp_valid", c), {29'd0, rv}, 0);
      next_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/itcm_arbiter.md
ITCM_ARBITER -- requirements
Module: itcm_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default ITCM_ADDR_WIDTH, byte-address width of the ITCM.
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive denied cycles before the IFU is boosted.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Per port P in {ifu, lsu, dbg}: P_req_valid in 1, P_req_ready out 1, P_req_addr in ADDR_WIDTH (byte), P_req_we in 1, P_req_be in 4, P_req_wdata in 32.
REQ-006 Per port P: P_rsp_valid out 1, P_rsp_ready in 1, P_rsp_rdata out 32.
REQ-007 ram_cs out 1, ram_we out 1, ram_be out 4, ram_addr out ADDR_WIDTH-2 (word), ram_wdata out 32, ram_rdata in 32 (valid one cycle after ram_cs).

Function
REQ-008 At most one port SHALL be granted per cycle; the grant is combinational and P_req_ready=1 only for the granted port.
REQ-009 A port SHALL be eligible only if its response buffer is empty and it has no in-flight access, or its in-flight response is accepted this cycle (P_rsp_ready=1).
REQ-010 Priority among eligible valid requesters SHALL be dbg > lsu > ifu, except when boosted (REQ-015).
REQ-011 On grant: ram_cs=1, ram_we=P_req_we, ram_be=P_req_be, ram_addr=P_req_addr[ADDR_WIDTH-1:2], ram_wdata=P_req_wdata; addr[1:0] ignored; ram_cs=0 when no grant.
REQ-012 Response SHALL return in cycle T+1 for a grant in T: P_rsp_valid=1, P_rsp_rdata=ram_rdata for reads, 32'h0 for writes.
REQ-013 If P_rsp_ready=0 in T+1, rdata SHALL be captured into the port's 1-entry buffer and P_rsp_valid held with stable data until accepted; buffer drains in the cycle P_rsp_ready=1.
REQ-014 Back-to-back grants to the same port with P_rsp_ready=1 SHALL sustain one access per cycle.
REQ-015 ifu starvation counter: increments when ifu_req_valid=1 and ifu not granted; clears on ifu grant or ifu_req_valid=0; saturates at STARVE_LIMIT; when equal to STARVE_LIMIT ifu SHALL take top priority if eligible.
REQ-016 Boost SHALL last exactly until the ifu grant that clears the counter.
REQ-017 A request not granted SHALL be held by the requester (valid/addr/data stable); the arbiter captures nothing from ungranted ports.
REQ-018 P_rsp_valid SHALL never assert for a port without a preceding grant; responses SHALL be in grant order per port.

Reset
REQ-019 On rst_n=0, asynchronously: all P_rsp_valid=0, buffers empty, in-flight flags cleared, starvation counter 0, all P_rsp_rdata=0.
REQ-020 During reset ram_cs=0 and all P_req_ready=0.
REQ-021 An access in flight when reset asserts SHALL be dropped with no response after release.
REQ-022 First grant possible in the first cycle after rst_n deasserts.

Structure
REQ-023 Port index constants (PORT_IFU=0, PORT_LSU=1, PORT_DBG=2) and STARVE_LIMIT default SHALL live in the shared defines file.
REQ-024 One sub-module itcm_rsp_buf (1-entry response buffer with valid/ready) SHALL be instantiated per port.
REQ-025 Grant logic, in-flight tracking and starvation counter SHALL reside in itcm_arbiter.

Verification
REQ-026 Single ifu read addr 0x10, mem word4=0xDEADBEEF, rsp_ready=1 -> ifu_rsp_valid next cycle, rdata 0xDEADBEEF, ram_addr=4.
REQ-027 All three valid same cycle, reads to 0x0/0x4/0x8 -> grants dbg, lsu, ifu in consecutive cycles, each response one cycle after its grant.
REQ-028 lsu continuous requests, ifu valid, STARVE_LIMIT=8 -> ifu granted on the 9th cycle, counter returns to 0, lsu resumes next cycle.
REQ-029 lsu read granted, lsu_rsp_ready=0 for 3 cycles -> lsu_rsp_valid held 3 cycles with stable data, no lsu grant until accepted, ifu served meanwhile.
REQ-030 dbg write be=4'b0011 data 0x12345678 to 0x20 then ifu read 0x20 -> ram_we/be as given, dbg rdata 0, ifu sees lower halfword 0x5678 merged.
REQ-031 rst_n low in cycle after lsu grant -> no lsu_rsp_valid after release, all outputs at reset values.
